// File: rtl/vga_timing_pkg.sv
// Shared timing constants, image geometry and types for the 640x480@60 raster.
package vga_timing_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START_DEF = H_VISIBLE_DEF + H_FP_DEF;
  localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int VS_START_DEF = V_VISIBLE_DEF + V_FP_DEF;
  localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  localparam logic SYNC_ACTIVE_DEF = 1'b0;
  localparam int   PIPE_DLY_DEF    = 2;

  // Downscaled background image: one ROM texel covers a 4x4 pixel block.
  localparam int SCALE_SHIFT_DEF = 2;
  localparam int ROM_W_DEF       = 160;
  localparam int ROM_H_DEF       = 120;
  localparam int ROM_DEPTH       = ROM_W_DEF * ROM_H_DEF;

  localparam int COORD_W    = 10;
  localparam int ROM_ADDR_W = 15;

  typedef logic [COORD_W-1:0]    coord_t;
  typedef logic [ROM_ADDR_W-1:0] rom_addr_t;

  function automatic logic sync_level(input logic in_pulse, input logic active);
    return in_pulse ? active : ~active;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Async-reset shift register that re-times sync/blank to match renderer pipelines.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout_o = din_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // NOTE: every stage is reset so a mid-frame reset cannot leak stale sync levels to the monitor.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else begin
          stage_q[0] <= din_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: counters, sync/blank, downscaled ROM address, frame tick/count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE   = H_VISIBLE_DEF,
  parameter int   H_FP        = H_FP_DEF,
  parameter int   H_SYNC      = H_SYNC_DEF,
  parameter int   H_BP        = H_BP_DEF,
  parameter int   V_VISIBLE   = V_VISIBLE_DEF,
  parameter int   V_FP        = V_FP_DEF,
  parameter int   V_SYNC      = V_SYNC_DEF,
  parameter int   V_BP        = V_BP_DEF,
  parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEF,
  parameter int   SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int   ROM_W       = ROM_W_DEF,
  parameter int   PIPE_DLY    = PIPE_DLY_DEF
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic [14:0] rom_addr,
  output logic        hs_d,
  output logic        vs_d,
  output logic        blank_d,
  output logic        frame_tick,
  output logic [7:0]  frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t    X_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t    Y_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t    X_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t    Y_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t    HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t    HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t    VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t    VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t    ROW_MASK = coord_t'((1 << SCALE_SHIFT) - 1);
  localparam rom_addr_t ROW_STEP = rom_addr_t'(ROM_W);

  localparam logic [2:0] DLY_RESET = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

  coord_t    x_q, x_d;
  coord_t    y_q, y_d;
  rom_addr_t row_base_q, row_base_d;
  rom_addr_t rom_addr_q, rom_addr_d;
  logic      visible_q, visible_d;
  logic      hsync_q, hsync_d;
  logic      vsync_q, vsync_d;
  logic      tick_q, tick_d;
  logic      line_wrap, frame_end;
  logic [7:0] frame_count_q;

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    line_wrap  = (x_q == X_LAST);
    frame_end  = line_wrap && (y_q == Y_LAST);
    x_d        = line_wrap ? '0 : x_q + 1'b1;
    y_d        = y_q;
    row_base_d = row_base_q;

    if (line_wrap) begin
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      if (y_d == '0) begin
        row_base_d = '0;
      end else if ((y_d & ROW_MASK) == '0) begin
        row_base_d = row_base_q + ROW_STEP;
      end
    end

    // Outputs are derived from the next position so they line up with DrawX/DrawY.
    visible_d  = (x_d < X_VIS) && (y_d < Y_VIS);
    hsync_d    = sync_level((x_d >= HS_START) && (x_d <= HS_END), SYNC_ACTIVE);
    vsync_d    = sync_level((y_d >= VS_START) && (y_d <= VS_END), SYNC_ACTIVE);
    rom_addr_d = visible_d ? row_base_d + rom_addr_t'(x_d >> SCALE_SHIFT) : '0;
    tick_d     = (x_d == X_LAST) && (y_d == Y_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      row_base_q    <= '0;
      rom_addr_q    <= '0;
      visible_q     <= 1'b1;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      tick_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      rom_addr_q <= rom_addr_d;
      visible_q  <= visible_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      tick_q     <= tick_d;
      if (frame_end) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DLY),
    .RESET_VAL (DLY_RESET)
  ) u_sync_delay (
    .clk    (vga_clk),
    .rst_n  (reset_n),
    .din_i  ({hsync_q, vsync_q, visible_q}),
    .dout_o ({hs_d, vs_d, blank_d})
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = visible_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign rom_addr    = rom_addr_q;
  assign frame_tick  = tick_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size raster plus a tiny raster for frame-level behaviour.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Tiny geometry: 12x12 raster, 8x8 visible, so hundreds of frames fit in a short run.
  localparam int S_HV = 8, S_HFP = 1, S_HS = 2, S_HBP = 1;
  localparam int S_VV = 8, S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_ROMW = 2;

  typedef struct {int hv, hfp, hs, hbp, vv, vfp, vs, vbp, romw;} geom_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank, hs, vs;
    logic [14:0] rom;
    logic        hs_d, vs_d, blank_d;
    logic        tick;
    logic [7:0]  fc;
  } obs_t;

  typedef struct {int inst; obs_t exp;} sb_t;
  typedef struct {int inst; int x; int y; logic [14:0] rom; logic blank;} vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #20 clk = ~clk;

  logic [9:0] dx, dy, s_dx, s_dy;
  logic blank, hs, vs, hs_d, vs_d, blank_d, tick;
  logic s_blank, s_hs, s_vs, s_hs_d, s_vs_d, s_blank_d, s_tick;
  logic [14:0] rom, s_rom;
  logic [7:0] fc, s_fc;

  vga_timing_gen dut (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(dx), .DrawY(dy), .blank(blank), .hs(hs), .vs(vs),
    .rom_addr(rom), .hs_d(hs_d), .vs_d(vs_d), .blank_d(blank_d), .frame_tick(tick),
    .frame_count(fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_ACTIVE(1'b0), .SCALE_SHIFT(2), .ROM_W(S_ROMW), .PIPE_DLY(2)
  ) dut_s (
    .vga_clk(clk), .reset_n(rst_n), .DrawX(s_dx), .DrawY(s_dy), .blank(s_blank), .hs(s_hs),
    .vs(s_vs), .rom_addr(s_rom), .hs_d(s_hs_d), .vs_d(s_vs_d), .blank_d(s_blank_d),
    .frame_tick(s_tick), .frame_count(s_fc)
  );

  geom_t g [2];
  int mx [2], my [2], mfc [2], mframes [2];
  logic [2:0] d1 [2], d2 [2];
  sb_t sb_q [$];
  vec_t vecs [10];
  bit vdone [10];

  int n_vec = 0, n_err = 0, cyc = 0;
  int hs_cnt = 0, hs_first = -1, blank_cnt = 0;
  bit line_done = 0;
  int last_tick = -1, ticks_chk = 0;
  int vs_cnt = 0, vs_first = -1;
  bit vs_done = 0, wrap_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int h_total(int i);
    return g[i].hv + g[i].hfp + g[i].hs + g[i].hbp;
  endfunction

  function automatic int v_total(int i);
    return g[i].vv + g[i].vfp + g[i].vs + g[i].vbp;
  endfunction

  function automatic obs_t model_obs(int i, int x, int y);
    obs_t o;
    int hs0, vs0;
    hs0       = g[i].hv + g[i].hfp;
    vs0       = g[i].vv + g[i].vfp;
    o.x       = 10'(x);
    o.y       = 10'(y);
    o.blank   = (x < g[i].hv) && (y < g[i].vv);
    o.hs      = !(x >= hs0 && x < hs0 + g[i].hs);
    o.vs      = !(y >= vs0 && y < vs0 + g[i].vs);
    o.rom     = o.blank ? 15'((y / 4) * g[i].romw + x / 4) : 15'd0;
    o.tick    = (x == h_total(i) - 1) && (y == v_total(i) - 1);
    o.fc      = 8'(mfc[i]);
    {o.hs_d, o.vs_d, o.blank_d} = d2[i];
    return o;
  endfunction

  function automatic obs_t get_act(int i);
    obs_t o;
    if (i == 0) o = '{dx, dy, blank, hs, vs, rom, hs_d, vs_d, blank_d, tick, fc};
    else        o = '{s_dx, s_dy, s_blank, s_hs, s_vs, s_rom, s_hs_d, s_vs_d, s_blank_d, s_tick, s_fc};
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mfc[i] = 0; mframes[i] = 0;
      d1[i] = 3'b110; d2[i] = 3'b110;
    end
  endtask

  task automatic model_advance(int i);
    obs_t cur;
    cur   = model_obs(i, mx[i], my[i]);
    d2[i] = d1[i];
    d1[i] = {cur.hs, cur.vs, cur.blank};
    if (mx[i] == h_total(i) - 1) begin
      mx[i] = 0;
      if (my[i] == v_total(i) - 1) begin
        my[i] = 0;
        mfc[i] = (mfc[i] + 1) % 256;
        mframes[i]++;
      end else my[i]++;
    end else mx[i]++;
  endtask

  task automatic table_check(int i);
    obs_t a;
    for (int k = 0; k < 10; k++) begin
      if (!vdone[k] && vecs[k].inst == i && vecs[k].x == mx[i] && vecs[k].y == my[i]) begin
        vdone[k] = 1;
        a = get_act(i);
        check($sformatf("vec%0d inst%0d (%0d,%0d) {x,y,blank,rom}", k, i, vecs[k].x, vecs[k].y),
              {a.x, a.y, a.blank, a.rom}, {10'(vecs[k].x), 10'(vecs[k].y), vecs[k].blank, vecs[k].rom});
      end
    end
  endtask

  task automatic track();
    if (my[0] == 1) begin
      if (!hs) begin
        if (hs_cnt == 0) hs_first = int'(dx);
        hs_cnt++;
      end
      if (blank) blank_cnt++;
    end
    if (!line_done && my[0] == 2) begin
      line_done = 1;
      check("line1 hs width", 64'(hs_cnt), 64'(96));
      check("line1 hs start", 64'(hs_first), 64'(656));
      check("line1 blank width", 64'(blank_cnt), 64'(640));
      check("DrawY after line wrap", 64'(dy), 64'(2));
    end
    if (s_tick) begin
      if (last_tick >= 0 && ticks_chk < 3) begin
        check("small tick period", 64'(cyc - last_tick), 64'(144));
        ticks_chk++;
      end
      last_tick = cyc;
    end
    if (mframes[1] == 1 && !s_vs) begin
      if (vs_cnt == 0) vs_first = int'(s_dy);
      vs_cnt++;
    end
    if (!vs_done && mframes[1] == 2) begin
      vs_done = 1;
      check("small vs width", 64'(vs_cnt), 64'(24));
      check("small vs first line", 64'(vs_first), 64'(9));
    end
    if (!wrap_done && mframes[1] == 256 && mx[1] == 0 && my[1] == 0) begin
      wrap_done = 1;
      check("frame_count wrap", 64'(s_fc), 64'(0));
      check("raster after wrap", {s_dx, s_dy}, 20'd0);
    end
  endtask

  // mode 1: compare every cycle; mode 2: compare at line starts only.
  task automatic step(input int mode);
    sb_t e;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      model_advance(i);
      if (mode == 1 || (mode == 2 && mx[i] == 0)) begin
        e.inst = i;
        e.exp  = model_obs(i, mx[i], my[i]);
        sb_q.push_back(e);
      end
    end
    @(negedge clk);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("raster%0d (%0d,%0d)", e.inst, e.exp.x, e.exp.y),
            64'(get_act(e.inst)), 64'(e.exp));
    end
    for (int i = 0; i < 2; i++) table_check(i);
    track();
    cyc++;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s reset inst%0d", tag, i), 64'(get_act(i)), 64'(model_obs(i, 0, 0)));
      table_check(i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s reset held inst%0d", tag, i), 64'(get_act(i)), 64'(model_obs(i, 0, 0)));
    #5 rst_n = 1'b1;
  endtask

  initial begin
    g[0] = '{H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
             V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF, ROM_W_DEF};
    g[1] = '{S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP, S_ROMW};

    vecs[0] = '{0,   0,  0,   15'd0, 1'b1};
    vecs[1] = '{0,   4,  4, 15'd161, 1'b1};
    vecs[2] = '{0,   7,  3,   15'd1, 1'b1};
    vecs[3] = '{0, 640, 10,   15'd0, 1'b0};
    vecs[4] = '{0, 639, 11, 15'd479, 1'b1};
    vecs[5] = '{0, 100,  5, 15'd185, 1'b1};
    vecs[6] = '{1,   0,  0,   15'd0, 1'b1};
    vecs[7] = '{1,   7,  7,   15'd3, 1'b1};
    vecs[8] = '{1,   4,  8,   15'd0, 1'b0};
    vecs[9] = '{1,   3,  4,   15'd2, 1'b1};
    for (int k = 0; k < 10; k++) vdone[k] = 0;

    #3 do_reset("initial");
    step(1);
    check("first edge DrawX", 64'(dx), 64'(1));
    check("first edge DrawY", 64'(dy), 64'(0));

    // Run to the middle of the line-12 sync pulse with full per-cycle comparison.
    for (int k = 1; k < 12 * 800 + 700; k++) step(1);
    check("hs_d inside sync pulse", 64'(hs_d), 64'(0));

    #5;
    do_reset("mid-sync");
    check("hs_d after mid-sync reset", 64'(hs_d), 64'(1));

    // Long run on the tiny raster through the 255 -> 0 frame counter wrap.
    for (int k = 0; k < 257 * 144; k++) step(2);
    check("small frame_count after 257 frames", 64'(s_fc), 64'(1));
    check("default frame_count unchanged", 64'(fc), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
